// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned ADRS_W  = 8;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned RDATA_W = 16;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // One requester's transaction as presented to the arbiter.
    typedef struct packed {
        logic              rw;
        logic [ADRS_W-1:0] adrs;
        logic [DATA_W-1:0] dout;
    } xact_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin winner selection; rptr only matters when both ports request.
module rr_pick
    import mem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic rptr,
    output logic winner_c,
    output logic valid_c
);

    always_comb begin
        winner_c = PORT0;
        valid_c  = req0 | req1;
        if (req0 && req1) begin
            winner_c = rptr;
        end else if (req1) begin
            winner_c = PORT1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory bus arbiter: grant, fixed-latency access, one-cycle done pulse.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                req0,
    input  logic                req1,
    input  logic                rw0,
    input  logic                rw1,
    input  logic [ADRS_W-1:0]   adrs0,
    input  logic [ADRS_W-1:0]   adrs1,
    input  logic [DATA_W-1:0]   dout0,
    input  logic [DATA_W-1:0]   dout1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                done0,
    output logic                done1,
    output logic [RDATA_W-1:0]  rdata,
    output logic                mem_en,
    output logic                mem_rw,
    output logic [ADRS_W-1:0]   mem_adrs,
    output logic [DATA_W-1:0]   mem_dout,
    input  logic [RDATA_W-1:0]  mem_din
);

    state_t           state;
    logic             rptr;
    logic             port;
    logic [CNT_W-1:0] cnt;
    logic             win_c;
    logic             win_valid_c;
    xact_t            sel_c;

    rr_pick u_rr_pick (
        .req0     (req0),
        .req1     (req1),
        .rptr     (rptr),
        .winner_c (win_c),
        .valid_c  (win_valid_c)
    );

    // Mux the winning port's request fields.
    always_comb begin
        sel_c.rw   = rw0;
        sel_c.adrs = adrs0;
        sel_c.dout = dout0;
        if (win_c == PORT1) begin
            sel_c.rw   = rw1;
            sel_c.adrs = adrs1;
            sel_c.dout = dout1;
        end
    end

    // The mem_* registers double as the latched transaction, so they hold outside ACCESS.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            rptr     <= PORT0;
            port     <= PORT0;
            cnt      <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            rdata    <= '0;
            mem_en   <= 1'b0;
            mem_rw   <= RW_READ;
            mem_adrs <= '0;
            mem_dout <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid_c) begin
                        port     <= win_c;
                        gnt0     <= (win_c == PORT0);
                        gnt1     <= (win_c == PORT1);
                        mem_en   <= 1'b1;
                        mem_rw   <= sel_c.rw;
                        mem_adrs <= sel_c.adrs;
                        mem_dout <= sel_c.dout;
                        cnt      <= CNT_W'(MEM_LAT - 1);
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        mem_en <= 1'b0;
                        gnt0   <= 1'b0;
                        gnt1   <= 1'b0;
                        if (mem_rw == RW_READ) begin
                            rdata <= mem_din;
                        end
                        done0  <= (port == PORT0);
                        done1  <= (port == PORT1);
                        state  <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    rptr  <= ~port;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3, shared inputs.
module tb_mem_arbiter;

    logic        clk;
    logic        clr;
    logic        req0, req1, rw0, rw1;
    logic [7:0]  adrs0, adrs1, dout0, dout1;
    logic [15:0] mem_din;

    logic        d1_gnt0, d1_gnt1, d1_done0, d1_done1, d1_mem_en, d1_mem_rw;
    logic [15:0] d1_rdata;
    logic [7:0]  d1_mem_adrs, d1_mem_dout;
    logic        d3_gnt0, d3_gnt1, d3_done0, d3_done1, d3_mem_en, d3_mem_rw;
    logic [15:0] d3_rdata;
    logic [7:0]  d3_mem_adrs, d3_mem_dout;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.MEM_LAT(1)) dut1 (
        .clk(clk), .clr(clr), .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .adrs0(adrs0), .adrs1(adrs1), .dout0(dout0), .dout1(dout1),
        .gnt0(d1_gnt0), .gnt1(d1_gnt1), .done0(d1_done0), .done1(d1_done1),
        .rdata(d1_rdata), .mem_en(d1_mem_en), .mem_rw(d1_mem_rw),
        .mem_adrs(d1_mem_adrs), .mem_dout(d1_mem_dout), .mem_din(mem_din)
    );

    mem_arbiter #(.MEM_LAT(3)) dut3 (
        .clk(clk), .clr(clr), .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .adrs0(adrs0), .adrs1(adrs1), .dout0(dout0), .dout1(dout1),
        .gnt0(d3_gnt0), .gnt1(d3_gnt1), .done0(d3_done0), .done1(d3_done1),
        .rdata(d3_rdata), .mem_en(d3_mem_en), .mem_rw(d3_mem_rw),
        .mem_adrs(d3_mem_adrs), .mem_dout(d3_mem_dout), .mem_din(mem_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [37:0] RST_VEC = {6'b000001, 8'h00, 8'h00, 16'h0000};

    task automatic settle();
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [37:0] v1, v3;
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req0 = 1'($urandom); req1 = 1'($urandom);
            rw0  = 1'($urandom); rw1  = 1'($urandom);
            adrs0 = 8'($urandom); adrs1 = 8'($urandom);
            dout0 = 8'($urandom); dout1 = 8'($urandom);
            mem_din = 16'($urandom);
            @(negedge clk);
            v1 = {d1_gnt0, d1_gnt1, d1_done0, d1_done1, d1_mem_en, d1_mem_rw, d1_mem_adrs, d1_mem_dout, d1_rdata};
            v3 = {d3_gnt0, d3_gnt1, d3_done0, d3_done1, d3_mem_en, d3_mem_rw, d3_mem_adrs, d3_mem_dout, d3_rdata};
            checks++;
            if (v1 !== RST_VEC) begin
                failures++;
                $display("FAIL reset_d1 cyc%0d got=%h want=%h", i, v1, RST_VEC);
            end
            checks++;
            if (v3 !== RST_VEC) begin
                failures++;
                $display("FAIL reset_d3 cyc%0d got=%h want=%h", i, v3, RST_VEC);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if ({d1_mem_en, d3_mem_en} !== 2'b00) begin
                failures++;
                $display("FAIL idle_mem_en got=%b want=00", {d1_mem_en, d3_mem_en});
            end
        end
    endtask

    task automatic test_single_read();
        settle();
        mem_din = 16'hA080;
        rw0 = 1'b1; adrs0 = 8'h80; dout0 = 8'h12; req0 = 1'b1;
        @(negedge clk);
        checks++;
        if ({d1_gnt0, d1_gnt1, d1_mem_en, d1_mem_rw, d1_mem_adrs} !== {4'b1011, 8'h80}) begin
            failures++;
            $display("FAIL read_grant got=%b_%h want=1011_80",
                     {d1_gnt0, d1_gnt1, d1_mem_en, d1_mem_rw}, d1_mem_adrs);
        end
        req0 = 1'b0; adrs0 = 8'h11; rw0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({d1_done0, d1_done1, d1_gnt0, d1_mem_en} !== 4'b1000) begin
            failures++;
            $display("FAIL read_done got=%b want=1000", {d1_done0, d1_done1, d1_gnt0, d1_mem_en});
        end
        checks++;
        if (d1_rdata !== 16'hA080) begin
            failures++;
            $display("FAIL read_rdata got=%h want=a080", d1_rdata);
        end
        @(negedge clk);
        checks++;
        if ({d1_done0, d1_done1, d1_mem_en} !== 3'b000) begin
            failures++;
            $display("FAIL read_done_pulse got=%b want=000", {d1_done0, d1_done1, d1_mem_en});
        end
        checks++;
        if ({d1_mem_rw, d1_mem_adrs} !== {1'b1, 8'h80}) begin
            failures++;
            $display("FAIL read_hold got=%b_%h want=1_80", d1_mem_rw, d1_mem_adrs);
        end
    endtask

    task automatic test_single_write();
        settle();
        mem_din = 16'h5555;
        rw1 = 1'b0; adrs1 = 8'h0F; dout1 = 8'h4F; req1 = 1'b1;
        @(negedge clk);
        checks++;
        if ({d1_gnt0, d1_gnt1, d1_mem_en, d1_mem_rw, d1_mem_adrs, d1_mem_dout} !== {4'b0110, 8'h0F, 8'h4F}) begin
            failures++;
            $display("FAIL write_grant got=%b_%h_%h want=0110_0f_4f",
                     {d1_gnt0, d1_gnt1, d1_mem_en, d1_mem_rw}, d1_mem_adrs, d1_mem_dout);
        end
        req1 = 1'b0; dout1 = 8'hEE;
        @(negedge clk);
        checks++;
        if ({d1_done0, d1_done1, d1_gnt1, d1_mem_en} !== 4'b0100) begin
            failures++;
            $display("FAIL write_done got=%b want=0100", {d1_done0, d1_done1, d1_gnt1, d1_mem_en});
        end
        checks++;
        if (d1_rdata !== 16'hA080) begin
            failures++;
            $display("FAIL write_rdata got=%h want=a080", d1_rdata);
        end
        @(negedge clk);
        checks++;
        if ({d1_done0, d1_done1} !== 2'b00) begin
            failures++;
            $display("FAIL write_done_pulse got=%b want=00", {d1_done0, d1_done1});
        end
        checks++;
        if (d1_mem_dout !== 8'h4F) begin
            failures++;
            $display("FAIL write_hold got=%h want=4f", d1_mem_dout);
        end
    endtask

    task automatic test_contention();
        int   ng;
        int   order [6];
        int   gcyc  [6];
        logic [7:0] gadr [6];
        logic prev;
        bit   overlap;
        settle();
        ng = 0; prev = 1'b0; overlap = 1'b0;
        rw0 = 1'b1; rw1 = 1'b1; adrs0 = 8'hA0; adrs1 = 8'hB1;
        req0 = 1'b1; req1 = 1'b1;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            @(negedge clk);
            if ((d1_gnt0 && d1_gnt1) || (d1_done0 && d1_done1)) overlap = 1'b1;
            if ((d1_gnt0 || d1_gnt1) && !prev) begin
                order[ng] = d1_gnt1 ? 1 : 0;
                gadr[ng]  = d1_mem_adrs;
                gcyc[ng]  = c;
                ng++;
            end
            prev = d1_gnt0 || d1_gnt1;
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if ((d1_gnt0 && d1_gnt1) || (d1_done0 && d1_done1)) overlap = 1'b1;
        end
        checks++;
        if (ng != 6) begin
            failures++;
            $display("FAIL rr_grant_count got=%0d want=6", ng);
        end
        for (int i = 0; i < ng; i++) begin
            checks++;
            if (order[i] != (i % 2)) begin
                failures++;
                $display("FAIL rr_order idx%0d got=%0d want=%0d", i, order[i], i % 2);
            end
            checks++;
            if (gadr[i] !== ((i % 2) ? 8'hB1 : 8'hA0)) begin
                failures++;
                $display("FAIL rr_adrs idx%0d got=%h want=%h", i, gadr[i], (i % 2) ? 8'hB1 : 8'hA0);
            end
        end
        for (int i = 1; i < ng; i++) begin
            checks++;
            if (gcyc[i] - gcyc[i-1] != 3) begin
                failures++;
                $display("FAIL rr_spacing idx%0d got=%0d want=3", i, gcyc[i] - gcyc[i-1]);
            end
        end
        checks++;
        if (overlap) begin
            failures++;
            $display("FAIL rr_exclusive got=overlap want=none");
        end
    endtask

    task automatic test_lat3_req_drop();
        int n_en, n_gnt, n_done0, n_done1;
        logic [15:0] rd_at_done;
        settle();
        mem_din = 16'h3C3C;
        rw0 = 1'b1; adrs0 = 8'h33; req0 = 1'b1;
        n_en = 0; n_gnt = 0; n_done0 = 0; n_done1 = 0; rd_at_done = 16'h0000;
        @(negedge clk);
        req0 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            if (d3_mem_en) n_en++;
            if (d3_gnt0) n_gnt++;
            if (d3_done1) n_done1++;
            if (d3_done0) begin
                n_done0++;
                rd_at_done = d3_rdata;
            end
        end
        checks++;
        if (n_en != 3) begin
            failures++;
            $display("FAIL lat3_mem_en_cycles got=%0d want=3", n_en);
        end
        checks++;
        if (n_gnt != 3) begin
            failures++;
            $display("FAIL lat3_gnt_cycles got=%0d want=3", n_gnt);
        end
        checks++;
        if (n_done0 != 1 || n_done1 != 0) begin
            failures++;
            $display("FAIL lat3_done got=%0d/%0d want=1/0", n_done0, n_done1);
        end
        checks++;
        if (rd_at_done !== 16'h3C3C) begin
            failures++;
            $display("FAIL lat3_rdata got=%h want=3c3c", rd_at_done);
        end
    endtask

    task automatic test_clr_abort();
        logic [37:0] v3;
        settle();
        rw1 = 1'b0; adrs1 = 8'h44; dout1 = 8'h55; req1 = 1'b1;
        @(negedge clk);
        checks++;
        if ({d3_gnt1, d3_mem_en} !== 2'b11) begin
            failures++;
            $display("FAIL abort_grant got=%b want=11", {d3_gnt1, d3_mem_en});
        end
        @(negedge clk);
        clr = 1'b0;
        req1 = 1'b0;
        #1;
        v3 = {d3_gnt0, d3_gnt1, d3_done0, d3_done1, d3_mem_en, d3_mem_rw, d3_mem_adrs, d3_mem_dout, d3_rdata};
        checks++;
        if (v3 !== RST_VEC) begin
            failures++;
            $display("FAIL abort_reset got=%h want=%h", v3, RST_VEC);
        end
        @(negedge clk);
        checks++;
        if ({d3_done0, d3_done1, d3_gnt1} !== 3'b000) begin
            failures++;
            $display("FAIL abort_no_done got=%b want=000", {d3_done0, d3_done1, d3_gnt1});
        end
        clr = 1'b1;
        rw0 = 1'b1; adrs0 = 8'h66; rw1 = 1'b1; adrs1 = 8'h77;
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        checks++;
        if ({d3_gnt0, d3_gnt1, d3_done1, d3_mem_adrs} !== {3'b100, 8'h66}) begin
            failures++;
            $display("FAIL abort_resume got=%b_%h want=100_66", {d3_gnt0, d3_gnt1, d3_done1}, d3_mem_adrs);
        end
        req0 = 1'b0; req1 = 1'b0;
        settle();
    endtask

    initial begin
        clr = 1'b0;
        req0 = 1'b0; req1 = 1'b0; rw0 = 1'b1; rw1 = 1'b1;
        adrs0 = 8'h00; adrs1 = 8'h00; dout0 = 8'h00; dout1 = 8'h00;
        mem_din = 16'h0000;
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_lat3_req_drop();
        test_clr_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
